spi_regbus_master: RTL
======================

Name: spi_regbus_master

Overview:
- SPI slave front-end that masters the internal 8-bit register bus (address, data, rd, wr).
- It sits directly upstream of every register and register FIFO instance.
- It converts framed SPI transactions from the host MCU into single-cycle rd/wr strobes, with optional address auto-increment and an explicit burst length.
- Burst length is explicit so that FIFO-backed reads never pop extra entries.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for spi_cs_n, spi_sclk and spi_mosi (minimum 2).
- FILL, 8'h00: byte returned on spi_miso for read slots beyond the burst length.

Ports:
- clk  in  1  system clock; must be at least 16x the spi_sclk frequency.
- nreset  in  1  synchronous, active-low reset.
- spi_cs_n  in  1  chip select, active low, asynchronous to clk.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first; 0 when not in a read data phase.
- address  out  8  register bus address.
- data  inout  8  register bus data; driven only while wr=1, otherwise 8'hZZ.
- rd  out  1  one-clk read strobe; bus data is sampled in the same cycle.
- wr  out  1  one-clk write strobe.
- busy  out  1  high from the synchronised cs_n fall to the synchronised cs_n rise.

Behaviour:
- Reset (nreset=0 at a clk edge): state=IDLE; address=8'h00; rd=0; wr=0; data=Z; spi_miso=0; busy=0; bit/byte counters cleared. Reset mid-transaction abandons the frame; further SCLK activity is ignored until cs_n is seen high and then low again.
- Synchronisation: cs_n, sclk and mosi pass through SYNC_STAGES flops. Rising and falling edges are detected from the last two stages, so an event lags its pin edge by SYNC_STAGES+1 clks.
- Frame format: byte0 CMD, byte1 ADDR, byte2 LEN, then data bytes.
  - CMD[7]: 1 = read, 0 = write.
  - CMD[6]: 1 = auto-increment address.
  - CMD[5:0]: ignored.
  - LEN: number of bus accesses; 0 means 256.
- States:
  - IDLE -> CMD on sync cs_n fall.
  - CMD -> ADDR -> LEN, each after 8 sclk rising edges; mosi is sampled on each rising edge.
  - LEN -> WDATA or RDATA according to CMD[7].
  - WDATA/RDATA -> DRAIN when remaining count reaches 0. DRAIN shifts in and ignores mosi; read slots output FILL.
  - Any state -> IDLE on sync cs_n rise.
- Write:
  - On the 8th rising edge of each data byte while remaining>0: one clk with wr=1, data=received byte, address=current address.
  - Then remaining decrements, and address increments (8-bit wrap, 8'hFF -> 8'h00) if autoinc is set.
- Read:
  - On the clk after the 8th rising edge of the LEN byte (and of each read data byte while remaining>0): rd=1 for exactly one clk at the current address.
  - Bus data is captured into the tx shifter on that edge; remaining decrements and address auto-increments as for write.
  - The MSB is presented on spi_miso at the next detected sclk falling edge. Each subsequent falling edge shifts out the next bit.
  - Exactly LEN rd pulses are issued per frame, never more.
- Partial bytes: cs_n rising mid-byte discards the partial byte with no wr. An issued rd is never retracted; it only occurs when the next slot is owed.
- rd and wr are never asserted in the same clk. Neither is asserted in IDLE, CMD, ADDR or DRAIN.
- Between accesses, address holds its last value.
- Simultaneous sync cs_n rise and sclk edge: cs_n takes priority and the edge is ignored.

Test Plan:
- Write burst: CMD=8'h40, ADDR=8'h10, LEN=8'h03, data AA BB CC -> wr pulses at addresses 10/11/12 with data AA/BB/CC; exactly 3 wr; data=Z otherwise.
- Read, no autoinc, FIFO at 8'h20 preloaded 5 entries: CMD=8'h80, ADDR=8'h20, LEN=8'h02, 4 data slots -> exactly 2 rd pulses; miso returns entries 0 and 1, then 00 00; FIFO left with 3 entries.
- Auto-increment wrap: write CMD=8'h40, ADDR=8'hFF, LEN=8'h02 -> wr at FF then 00.
- LEN=0: write CMD=8'h00, ADDR=8'h05 with 256 bytes -> 256 wr pulses, all at 05; a 257th byte produces no wr.
- Abort: cs_n rises after 4 bits of the second write data byte -> only the first wr occurs; busy falls; the next frame decodes normally.
- Reset mid-read (nreset low during RDATA) -> rd/wr=0, miso=0, busy=0 the next clk; continued SCLK with cs_n still low produces no strobes.

Source files
------------

// File: rtl/spi_regbus_master.sv
// SPI (mode 0) slave front-end that masters the 8-bit internal register bus.
// Frame: CMD, ADDR, LEN, then data bytes; LEN bounds the number of rd/wr strobes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | cs_n high (or not yet re-armed after reset); bus quiet
// ST_CMD   | shifting in command byte (rd/wr, autoinc)
// ST_ADDR  | shifting in start address
// ST_LEN   | shifting in access count (0 = 256)
// ST_WDATA | each completed byte produces one wr strobe
// ST_RDATA | each completed byte owes the next slot, so one rd strobe
// ST_DRAIN | count exhausted; bytes ignored, read slots return FILL
`timescale 1ns/1ps
module spi_regbus_master #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL        = 8'h00
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] address,
  inout  wire  [7:0] data,
  output logic       rd,
  output logic       wr,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_LEN, ST_WDATA, ST_RDATA, ST_DRAIN
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;

  state_t     state_q;
  logic       armed_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic       cmd_rd_q, cmd_ai_q;
  logic [7:0] addr_q;
  logic [8:0] remain_q;
  logic [7:0] tx_q;
  logic       miso_q, rd_q, wr_q, busy_q;
  logic [7:0] wdata_q;

  logic       cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
  logic [7:0] byte_w;

  // Synchronisers are left unreset so that a reset with cs_n held low
  // cannot manufacture a fake cs_n fall.
  always_ff @(posedge clk) begin
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign byte_w    = {rx_q, mosi_s};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      cmd_rd_q  <= 1'b0;
      cmd_ai_q  <= 1'b0;
      addr_q    <= 8'h00;
      remain_q  <= 9'd0;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      if (cs_s) armed_q <= 1'b1;

      // Address/count advance the clk after the strobe so the strobe sees a stable address.
      if (rd_q || wr_q) begin
        remain_q <= remain_q - 9'd1;
        if (cmd_ai_q) addr_q <= addr_q + 8'd1;
      end

      if (state_q == ST_IDLE) begin
        busy_q    <= 1'b0;
        miso_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        if (armed_q && !cs_s) begin
          state_q <= ST_CMD;
          busy_q  <= 1'b1;
        end
      end else if (cs_s) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        miso_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
      end else begin
        if ((rd_q || wr_q) && remain_q == 9'd1) state_q <= ST_DRAIN;

        if (sclk_fall && cmd_rd_q && (state_q == ST_RDATA || state_q == ST_DRAIN)) begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end

        if (sclk_rise) begin
          rx_q      <= byte_w[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              ST_CMD: begin
                cmd_rd_q <= byte_w[7];
                cmd_ai_q <= byte_w[6];
                state_q  <= ST_ADDR;
              end
              ST_ADDR: begin
                addr_q  <= byte_w;
                state_q <= ST_LEN;
              end
              ST_LEN: begin
                remain_q <= {(byte_w == 8'h00), byte_w};
                if (cmd_rd_q) begin
                  state_q <= ST_RDATA;
                  rd_q    <= 1'b1;
                end else begin
                  state_q <= ST_WDATA;
                end
              end
              ST_WDATA: begin
                wr_q    <= 1'b1;
                wdata_q <= byte_w;
              end
              ST_RDATA: rd_q <= 1'b1;
              ST_DRAIN: if (cmd_rd_q) tx_q <= FILL;
              default: ;
            endcase
          end
        end
      end

      if (rd_q) tx_q <= data;
    end
  end

  assign spi_miso = miso_q;
  assign address  = addr_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign busy     = busy_q;
  assign data     = wr_q ? wdata_q : 8'hzz;

endmodule
